select_arbiter: RTL and testbench

SELECT_ARBITER -- requirements
Module: select_arbiter

---
 rtl/select_arbiter.sv | 96 +++++++++
 tb/tb_select_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/select_arbiter.sv
// Round-robin grant selector that drives the select lines of a downstream 2-to-4 decoder.
// A grant is held until done, until the holder drops its request, or until MAX_HOLD cycles pass.
module select_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       s1,
    output logic       s0,
    output logic       gnt_valid,
    output logic       expired
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] sel_q;
    logic [1:0] last_q;
    logic [7:0] hold_cnt_q;
    logic       gnt_valid_q;
    logic       expired_q;

    logic [1:0] pick_d;
    logic [1:0] cand;
    logic       holder_req_d;
    logic       timeout_d;
    logic       release_d;

    // Cyclic scan starting just after the last holder; the lowest offset wins.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pick_d = last_q + 2'd1;
        cand   = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                pick_d = cand;
            end
        end
        holder_req_d = req[sel_q];
        timeout_d    = (hold_cnt_q == 8'(MAX_HOLD - 1));
        release_d    = done || !holder_req_d || timeout_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            last_q      <= 2'd3;
            hold_cnt_q  <= 8'd0;
            gnt_valid_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    expired_q <= 1'b0;
                    if (req != 4'b0000) begin
                        sel_q       <= pick_d;
                        hold_cnt_q  <= 8'd0;
                        gnt_valid_q <= 1'b1;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        last_q      <= sel_q;
                        gnt_valid_q <= 1'b0;
                        // Only a pure timeout is flagged; a coincident done or drop wins.
                        expired_q   <= timeout_d && !done && holder_req_d;
                        state_q     <= IDLE;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + 8'd1;
                        expired_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_valid_q <= 1'b0;
                    expired_q   <= 1'b0;
                end
            endcase
        end
    end

    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign gnt_valid = gnt_valid_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_select_arbiter.sv
// Bench for select_arbiter: a reference model queues expected grants and releases,
// and a monitor pops them as the DUT raises and drops gnt_valid.
module tb_select_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] req  = 4'b0000;
    logic       done = 1'b0;
    logic       s1;
    logic       s0;
    logic       gnt_valid;
    logic       expired;

    select_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .s1        (s1),
        .s0        (s0),
        .gnt_valid (gnt_valid),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int edge_n;
        int idx;
    } grant_t;

    typedef struct {
        int edge_n;
        bit timed_out;
    } release_t;

    grant_t   gq[$];
    release_t rq[$];

    // Reference model: who holds the line, since which edge, and who was served last.
    int edge_cnt     = 0;
    bit m_busy       = 0;
    int m_last       = 3;
    int m_holder     = 0;
    int m_grant_edge = 0;

    always @(posedge clk) begin
        bit dropped;
        bit timeout;
        edge_cnt++;
        if (rst) begin
            if (m_busy) rq.push_back('{edge_n: edge_cnt, timed_out: 1'b0});
            m_busy = 0;
            m_last = 3;
        end else if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                if (req[(m_last + k) % 4]) begin
                    m_holder     = (m_last + k) % 4;
                    m_grant_edge = edge_cnt;
                    m_busy       = 1;
                    gq.push_back('{edge_n: edge_cnt, idx: m_holder});
                    break;
                end
            end
        end else begin
            dropped = !req[m_holder];
            timeout = (edge_cnt - m_grant_edge) == MAX_HOLD;
            if (done || dropped || timeout) begin
                rq.push_back('{edge_n: edge_cnt, timed_out: timeout && !done && !dropped});
                m_last = m_holder;
                m_busy = 0;
            end
        end
    end

    // Monitor: samples on the falling edge, pops expectations on gnt_valid transitions.
    logic prev_gv = 1'b0;
    int   cur_idx = -1;

    always @(negedge clk) begin
        grant_t     g;
        release_t   r;
        logic [3:0] dec;
        logic [3:0] exp_dec;
        bit         exp_expired;
        if (edge_cnt > 0) begin
            exp_expired = 0;
            if (gnt_valid === 1'b1 && prev_gv !== 1'b1) begin
                check("grant_expected", gq.size() != 0, 1);
                if (gq.size() != 0) begin
                    g = gq.pop_front();
                    check("grant_edge", edge_cnt, g.edge_n);
                    check("grant_idx", {s1, s0}, g.idx);
                    cur_idx = g.idx;
                end
            end
            if (prev_gv === 1'b1 && gnt_valid !== 1'b1) begin
                check("release_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    check("release_edge", edge_cnt, r.edge_n);
                    exp_expired = r.timed_out;
                end
                cur_idx = -1;
            end
            check("expired", expired, exp_expired);
            if (gnt_valid === 1'b1) begin
                for (int i = 0; i < 4; i++) dec[i] = ({s1, s0} == 2'(i));
                exp_dec = (cur_idx >= 0) ? 4'(1 << cur_idx) : 4'b0000;
                check("decoder_onehot", dec, exp_dec);
            end
            prev_gv = gnt_valid;
        end
    end

    task automatic wait_gv();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check("wait_grant", ok, 1);
    endtask

    initial begin
        int order[5];
        int hold_len;
        order = '{0, 1, 2, 3, 0};

        // Reset for one edge, then all four requesting with done one cycle after each grant.
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(negedge clk);
        check("rst_sel", {s1, s0}, 2'b00);
        check("rst_gnt_valid", gnt_valid, 1'b0);
        check("rst_expired", expired, 1'b0);
        rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gv();
            check("rr_order", {s1, s0}, order[g]);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check("rr_gap_low", gnt_valid, 1'b0);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Single persistent requester 2 runs into the hold limit and is regranted.
        req = 4'b0100;
        wait_gv();
        hold_len = 0;
        while (gnt_valid === 1'b1 && hold_len < 20) begin
            check("hold_sel", {s1, s0}, 2'b10);
            hold_len++;
            @(negedge clk);
        end
        check("hold_len", hold_len, MAX_HOLD);
        check("timeout_expired", expired, 1'b1);
        @(negedge clk);
        check("regrant_valid", gnt_valid, 1'b1);
        check("regrant_sel", {s1, s0}, 2'b10);
        check("regrant_expired", expired, 1'b0);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Holder 1 drops its request in its third cycle.
        req = 4'b0010;
        wait_gv();
        check("drop_sel", {s1, s0}, 2'b01);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("drop_gnt_valid", gnt_valid, 1'b0);
        check("drop_expired", expired, 1'b0);
        req = 4'b1111;
        wait_gv();
        check("after_drop_next", {s1, s0}, 2'b10);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // done arrives exactly at the timeout edge: release without an expired pulse.
        req = 4'b0001;
        wait_gv();
        for (int i = 1; i < MAX_HOLD; i++) @(negedge clk);
        check("late_done_still_held", gnt_valid, 1'b1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req = 4'b0000;
        check("late_done_gnt_valid", gnt_valid, 1'b0);
        check("late_done_expired", expired, 1'b0);
        repeat (3) @(negedge clk);

        // Reset while holder 3 is granted; requests present during reset go to 0 next.
        req = 4'b1000;
        wait_gv();
        check("pre_rst_sel", {s1, s0}, 2'b11);
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        check("mid_rst_sel", {s1, s0}, 2'b00);
        check("mid_rst_gnt_valid", gnt_valid, 1'b0);
        check("mid_rst_expired", expired, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_gnt_valid", gnt_valid, 1'b1);
        check("post_rst_sel", {s1, s0}, 2'b00);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Random traffic: sticky requests, sparse done, rare reset.
        repeat (600) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0; done = 1'b0; req = 4'b0000;
        repeat (5) @(negedge clk);
        check("grant_queue_drained", gq.size(), 0);
        check("release_queue_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
